// File: rtl/setpoint_ramp_ctrl.sv
// setpoint_ramp_ctrl
// Slew-limited setpoint sequencer feeding the 3LFCC modulator. Target updates from the
// UART decoder and the up/down buttons are arbitrated every cycle. The applied setpoint
// then walks toward the target by at most STEP_SIZE once every STEP_PERIOD+1 cycles.
//
// Ports:
//   clk_i         system clock (27 MHz)
//   rst_i         synchronous, active-high reset
//   uart_valid_i  strobe: uart_value_i is a new absolute target
//   uart_value_i  absolute target from the UART decoder
//   btn_up_i      debounced pulse: target += BTN_STEP (clamped to MAX_VALUE)
//   btn_dn_i      debounced pulse: target -= BTN_STEP (floored at 0)
//   hold_i        level: freezes ramping while high
//   setpoint_o    applied setpoint
//   target_o      current accepted target
//   busy_o        ramp state machine not idle
//   at_target_o   setpoint_o == target_o
//   drop_o        one-cycle pulse: a button request was discarded by arbitration
module setpoint_ramp_ctrl #(
    parameter logic [15:0] STEP_SIZE   = 16'd157,
    parameter int unsigned STEP_PERIOD = 2700,
    parameter logic [15:0] BTN_STEP    = 16'd1569,
    parameter logic [15:0] MAX_VALUE   = 16'd38825
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_valid_i,
    input  logic [15:0] uart_value_i,
    input  logic        btn_up_i,
    input  logic        btn_dn_i,
    input  logic        hold_i,
    output logic [15:0] setpoint_o,
    output logic [15:0] target_o,
    output logic        busy_o,
    output logic        at_target_o,
    output logic        drop_o
);

    localparam int unsigned CntW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StWait, StStep} state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     setpoint_q, setpoint_d;
    logic [15:0]     target_q, target_d;
    logic            drop_q, drop_d;

    logic [16:0] up_sum;
    logic [16:0] mag;
    logic        go_up;
    logic [15:0] delta;
    logic [15:0] stepped;

    // Target arbitration: UART wins over buttons; simultaneous up+down cancels.
    always_comb begin
        target_d = target_q;
        drop_d   = 1'b0;
        up_sum   = {1'b0, target_q} + {1'b0, BTN_STEP};
        if (uart_valid_i) begin
            target_d = (uart_value_i > MAX_VALUE) ? MAX_VALUE : uart_value_i;
            drop_d   = btn_up_i | btn_dn_i;
        end else if (btn_up_i && btn_dn_i) begin
            drop_d = 1'b1;
        end else if (btn_up_i) begin
            target_d = (up_sum > {1'b0, MAX_VALUE}) ? MAX_VALUE : up_sum[15:0];
        end else if (btn_dn_i) begin
            target_d = (target_q < BTN_STEP) ? 16'd0 : target_q - BTN_STEP;
        end
    end

    // One slew-limited step toward the current target. delta never exceeds the
    // distance to the target, so the 16-bit add/subtract below cannot wrap.
    always_comb begin
        go_up   = target_q > setpoint_q;
        mag     = go_up ? ({1'b0, target_q} - {1'b0, setpoint_q})
                        : ({1'b0, setpoint_q} - {1'b0, target_q});
        delta   = (mag > {1'b0, STEP_SIZE}) ? STEP_SIZE : mag[15:0];
        stepped = go_up ? setpoint_q + delta : setpoint_q - delta;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        setpoint_d = setpoint_q;
        unique case (state_q)
            StIdle: begin
                if (setpoint_q != target_q) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (!hold_i) begin
                    if (cnt_q == CntLast) begin
                        state_d = StStep;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StStep: begin
                if (!hold_i) begin
                    setpoint_d = stepped;
                    cnt_d      = '0;
                    state_d    = (stepped == target_q) ? StIdle : StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            setpoint_q <= 16'd0;
            target_q   <= 16'd0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            setpoint_q <= setpoint_d;
            target_q   <= target_d;
            drop_q     <= drop_d;
        end
    end

    assign setpoint_o  = setpoint_q;
    assign target_o    = target_q;
    assign busy_o      = (state_q != StIdle);
    assign at_target_o = (setpoint_q == target_q);
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_setpoint_ramp_ctrl.sv
// Scoreboard bench for setpoint_ramp_ctrl with STEP_PERIOD=4. Stimulus pushes the
// expected setpoint/target/drop events (value + cycle) into queues; a negedge monitor
// pops and compares every time an output changes or drop_o is seen high.
module tb_setpoint_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_valid;
    logic [15:0] uart_value;
    logic        btn_up;
    logic        btn_dn;
    logic        hold;
    logic [15:0] setpoint;
    logic [15:0] target;
    logic        busy;
    logic        at_target;
    logic        drop;

    setpoint_ramp_ctrl #(
        .STEP_SIZE  (16'd157),
        .STEP_PERIOD(4),
        .BTN_STEP   (16'd1569),
        .MAX_VALUE  (16'd38825)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .uart_valid_i(uart_valid),
        .uart_value_i(uart_value),
        .btn_up_i    (btn_up),
        .btn_dn_i    (btn_dn),
        .hold_i      (hold),
        .setpoint_o  (setpoint),
        .target_o    (target),
        .busy_o      (busy),
        .at_target_o (at_target),
        .drop_o      (drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int cyc;
        int aux;
    } ev_t;

    ev_t sp_q[$];
    ev_t tgt_q[$];
    ev_t drop_q[$];

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required=no event (cycle %0d)", name, act, cyc);
    endtask

    function automatic ev_t mk(input int v, input int c, input int a);
        ev_t e;
        e.val = v;
        e.cyc = c;
        e.aux = a;
        return e;
    endfunction

    // Monitor
    logic [15:0] prev_sp;
    logic [15:0] prev_tgt;
    ev_t         me;
    always @(negedge clk) begin
        if (mon_en) begin
            if (setpoint !== prev_sp) begin
                if (sp_q.size() == 0) begin
                    unexpected("setpoint_change", int'(setpoint));
                end else begin
                    me = sp_q.pop_front();
                    check("setpoint_value", int'(setpoint), me.val);
                    check("setpoint_cycle", cyc, me.cyc);
                    check("busy_after_step", int'(busy), me.aux);
                end
            end
            if (target !== prev_tgt) begin
                if (tgt_q.size() == 0) begin
                    unexpected("target_change", int'(target));
                end else begin
                    me = tgt_q.pop_front();
                    check("target_value", int'(target), me.val);
                    check("target_cycle", cyc, me.cyc);
                end
            end
            if (drop === 1'b1) begin
                if (drop_q.size() == 0) begin
                    unexpected("drop_pulse", cyc);
                end else begin
                    me = drop_q.pop_front();
                    check("drop_cycle", cyc, me.cyc);
                end
            end
        end
        prev_sp  = setpoint;
        prev_tgt = target;
    end

    // Called at a negedge; inputs are sampled on the following posedge.
    task automatic pulse(input logic u, input int v, input logic up, input logic dn);
        uart_valid = u;
        uart_value = v[15:0];
        btn_up     = up;
        btn_dn     = dn;
        @(negedge clk);
        uart_valid = 1'b0;
        btn_up     = 1'b0;
        btn_dn     = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag, input int sp_exp);
        check({tag, "_setpoint"}, int'(setpoint), sp_exp);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_at_target"}, int'(at_target), 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst        = 1'b1;
        uart_valid = 1'b0;
        uart_value = 16'd0;
        btn_up     = 1'b0;
        btn_dn     = 1'b0;
        hold       = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_setpoint", int'(setpoint), 0);
        check("reset_target", int'(target), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_at_target", int'(at_target), 1);
        check("reset_drop", int'(drop), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Ramp up to 1000: first step 6 cycles after target, then every 5
        c = cyc;
        tgt_q.push_back(mk(1000, c + 1, 0));
        for (int k = 0; k < 7; k++) begin
            sp_q.push_back(mk((k < 6) ? 157 * (k + 1) : 1000, c + 7 + 5 * k, (k < 6) ? 1 : 0));
        end
        pulse(1'b1, 1000, 1'b0, 1'b0);
        wait_until(c + 40);
        check_idle_outputs("ramp_done", 1000);

        // Clamp / saturate / arbitration, with hold high so the setpoint stays put
        hold = 1'b1;
        @(negedge clk);
        c = cyc; tgt_q.push_back(mk(38825, c + 1, 0)); pulse(1'b1, 50000, 1'b0, 1'b0);
        c = cyc; tgt_q.push_back(mk(38000, c + 1, 0)); pulse(1'b1, 38000, 1'b0, 1'b0);
        c = cyc; tgt_q.push_back(mk(38825, c + 1, 0)); pulse(1'b0, 0, 1'b1, 1'b0);
        c = cyc; tgt_q.push_back(mk(1000, c + 1, 0));  pulse(1'b1, 1000, 1'b0, 1'b0);
        c = cyc; tgt_q.push_back(mk(0, c + 1, 0));     pulse(1'b0, 0, 1'b0, 1'b1);
        c = cyc; tgt_q.push_back(mk(500, c + 1, 0));
        drop_q.push_back(mk(1, c + 1, 0));
        pulse(1'b1, 500, 1'b1, 1'b0);
        c = cyc; drop_q.push_back(mk(1, c + 1, 0));    pulse(1'b0, 0, 1'b1, 1'b1);
        check("both_buttons_target", int'(target), 500);
        c = cyc; tgt_q.push_back(mk(2069, c + 1, 0));  pulse(1'b0, 0, 1'b1, 1'b0);
        c = cyc; tgt_q.push_back(mk(500, c + 1, 0));   pulse(1'b0, 0, 1'b0, 1'b1);
        c = cyc; tgt_q.push_back(mk(1000, c + 1, 0));  pulse(1'b1, 1000, 1'b0, 1'b0);
        check("hold_busy", int'(busy), 1);
        hold = 1'b0;
        c = cyc;
        wait_until(c + 10);
        check_idle_outputs("zero_step", 1000);

        // Plain reset back to zero
        c = cyc;
        sp_q.push_back(mk(0, c + 1, 0));
        tgt_q.push_back(mk(0, c + 1, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Hold at 314 for 10 cycles, then retarget to 0
        c = cyc;
        tgt_q.push_back(mk(1000, c + 1, 0));
        tgt_q.push_back(mk(0, c + 23, 0));
        sp_q.push_back(mk(157, c + 7, 1));
        sp_q.push_back(mk(314, c + 12, 1));
        sp_q.push_back(mk(157, c + 27, 1));
        sp_q.push_back(mk(0, c + 32, 0));
        pulse(1'b1, 1000, 1'b0, 1'b0);
        wait_until(c + 12);
        hold = 1'b1;
        wait_until(c + 22);
        check("hold_frozen_setpoint", int'(setpoint), 314);
        check("hold_frozen_busy", int'(busy), 1);
        hold = 1'b0;
        pulse(1'b1, 0, 1'b0, 1'b0);
        wait_until(c + 40);
        check_idle_outputs("retarget_done", 0);

        // Reset mid-ramp while waiting at 471
        c = cyc;
        tgt_q.push_back(mk(1000, c + 1, 0));
        sp_q.push_back(mk(157, c + 7, 1));
        sp_q.push_back(mk(314, c + 12, 1));
        sp_q.push_back(mk(471, c + 17, 1));
        pulse(1'b1, 1000, 1'b0, 1'b0);
        wait_until(c + 19);
        check("midramp_setpoint", int'(setpoint), 471);
        check("midramp_busy", int'(busy), 1);
        sp_q.push_back(mk(0, c + 20, 0));
        tgt_q.push_back(mk(0, c + 20, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_target", int'(target), 0);
        check("midreset_drop", int'(drop), 0);
        check_idle_outputs("midreset", 0);
        wait_until(c + 60);
        check_idle_outputs("after_reset_quiet", 0);

        check("sp_queue_drained", sp_q.size(), 0);
        check("tgt_queue_drained", tgt_q.size(), 0);
        check("drop_queue_drained", drop_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
